// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// truth_table_sweeper_if : host/gate-side signal bundle of the sweeper
// Revision: 1.0
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       dut_in1;
  logic       dut_in2;
  logic       dut_in3;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       pass;
  logic [3:0] mismatch_count;

  // master = host plus the gate under test, slave = the sweeper itself
  modport master (
    output start, abort, dut_out,
    input  dut_in1, dut_in2, dut_in3, busy, done, result, pass, mismatch_count
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in1, dut_in2, dut_in3, busy, done, result, pass, mismatch_count
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : steps a 3-input gate through all combinations,
//                       captures its truth table and compares to EXPECTED
// Revision: 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED      = 8'hE1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  truth_table_sweeper_if.slave    sweep_if
);

  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       pass_q, pass_d;
  logic [3:0] mm_q, mm_d;
  logic [2:0] din_q, din_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] w_result_cap;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    pass_d   = pass_q;
    mm_d     = mm_q;

    // Result word with the bit for the current combination filled in
    w_result_cap             = result_q;
    w_result_cap[3'd7 - k_q] = sweep_if.dut_out;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        k_d   = 3'd0;
        cnt_d = 8'd0;
        if (sweep_if.abort) begin
          state_d  = ST_IDLE;
          result_d = 8'h00;
          pass_d   = 1'b0;
          mm_d     = 4'd0;
        end else if (sweep_if.start) begin
          state_d  = ST_APPLY;
          result_d = 8'h00;
          pass_d   = 1'b0;
          mm_d     = 4'd0;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_APPLY: begin
        if (sweep_if.abort) begin
          state_d  = ST_IDLE;
          k_d      = 3'd0;
          cnt_d    = 8'd0;
          result_d = 8'h00;
          pass_d   = 1'b0;
          mm_d     = 4'd0;
        end else if (cnt_q == C_SETTLE) begin
          result_d = w_result_cap;
          cnt_d    = 8'd0;
          if (k_q == 3'd7) begin
            state_d = ST_DONE;
            pass_d  = (w_result_cap == EXPECTED);
            mm_d    = popcount8(w_result_cap ^ EXPECTED);
          end else begin
            k_d = k_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        k_d      = 3'd0;
        cnt_d    = 8'd0;
        result_d = 8'h00;
        pass_d   = 1'b0;
        mm_d     = 4'd0;
      end
    endcase

    // Outputs are registered from the next state so they change with the edge
    busy_d = (state_d == ST_APPLY);
    done_d = (state_d == ST_DONE);
    din_d  = busy_d ? k_d : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      cnt_q    <= 8'd0;
      result_q <= 8'h00;
      pass_q   <= 1'b0;
      mm_q     <= 4'd0;
      din_q    <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sweep_if.dut_in1        = din_q[2];
  assign sweep_if.dut_in2        = din_q[1];
  assign sweep_if.dut_in3        = din_q[0];
  assign sweep_if.busy           = busy_q;
  assign sweep_if.done           = done_q;
  assign sweep_if.result         = result_q;
  assign sweep_if.pass           = pass_q;
  assign sweep_if.mismatch_count = mm_q;

endmodule

`default_nettype wire
